// File: rtl/freq_meter_pkg.sv
// Shared constants and the BCD converter state type for the frequency meter.
package freq_meter_pkg;

    localparam int CLK_HZ         = 100000000;
    localparam int CNT_W_DEFAULT  = 24;
    localparam int DIGITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result published in DONE.
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(CNT_W + 1);

    conv_state_t       state_reg;
    conv_state_t       state_next;
    logic [CW-1:0]     bit_cnt_reg;
    logic [CNT_W-1:0]  bin_reg;
    logic [BW-1:0]     acc_reg;
    logic [BW-1:0]     bcd_reg;
    logic [BW-1:0]     adj;
    logic [BW-1:0]     acc_step;
    logic [CNT_W-1:0]  bin_step;
    logic              last_step;

    // Add 3 to every digit >= 5 before the shift so it carries correctly.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                acc_reg[4*gi +: 4] + 4'd3 : acc_reg[4*gi +: 4];
    end

    assign acc_step  = {adj[BW-2:0], bin_reg[CNT_W-1]};
    assign bin_step  = {bin_reg[CNT_W-2:0], 1'b0};
    assign last_step = (bit_cnt_reg == CW'(CNT_W - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg <= '0;
            bin_reg     <= '0;
            acc_reg     <= '0;
            bcd_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_reg     <= bin;
                        acc_reg     <= '0;
                        bit_cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    bin_reg     <= bin_step;
                    acc_reg     <= acc_step;
                    bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    // Publish on the final shift so bcd and done appear together.
                    if (last_step) bcd_reg <= acc_step;
                end
                default: ;
            endcase
        end
    end

    assign bcd  = bcd_reg;
    assign done = (state_reg == DONE);

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter for an asynchronous input, with BCD result for display.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DIGITS      = DIGITS_DEFAULT
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sigin,
    output logic [CNT_W-1:0]      freq,
    output logic                  freq_valid,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid
);

    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic              s1_reg, s2_reg, s3_reg;
    logic              rise;
    logic [GW-1:0]     gate_cnt_reg;
    logic [CNT_W-1:0]  edge_cnt_reg;
    logic              sat_reg;
    logic [CNT_W-1:0]  freq_reg;
    logic              freq_valid_reg;
    logic              ovf_reg;
    logic              terminal;
    logic              at_max;
    logic              inc_sat;
    logic [CNT_W-1:0]  edge_inc;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= sigin;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise     = s2_reg & ~s3_reg;
    assign terminal = (gate_cnt_reg == GATE_LAST);
    assign at_max   = (edge_cnt_reg == CNT_MAX);
    assign inc_sat  = rise & at_max;
    assign edge_inc = (rise && !at_max) ? edge_cnt_reg + 1'b1 : edge_cnt_reg;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_reg   <= '0;
            edge_cnt_reg   <= '0;
            sat_reg        <= 1'b0;
            freq_reg       <= '0;
            freq_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            freq_valid_reg <= 1'b0;
            if (!en) begin
                gate_cnt_reg <= '0;
                edge_cnt_reg <= '0;
                sat_reg      <= 1'b0;
            end else if (terminal) begin
                // A rise in the terminal cycle is folded into the closing window.
                gate_cnt_reg   <= '0;
                edge_cnt_reg   <= '0;
                sat_reg        <= 1'b0;
                freq_reg       <= edge_inc;
                ovf_reg        <= sat_reg | inc_sat;
                freq_valid_reg <= 1'b1;
            end else begin
                gate_cnt_reg <= gate_cnt_reg + 1'b1;
                edge_cnt_reg <= edge_inc;
                sat_reg      <= sat_reg | inc_sat;
            end
        end
    end

    assign freq       = freq_reg;
    assign freq_valid = freq_valid_reg;
    assign ovf        = ovf_reg;

    bin2bcd_seq #(
        .CNT_W  (CNT_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .start  (freq_valid_reg),
        .bin    (freq_reg),
        .bcd    (bcd),
        .done   (bcd_valid)
    );

endmodule
